// File: rtl/fib_sequencer_pkg.sv
// Shared definitions for the Fibonacci run controller.
// Holds the controller state encoding, the default parameter widths and
// the clock_op value that stalls stepping.
package fib_sequencer_pkg;

  localparam int unsigned CLOCK_WIDTH_DEF = 6;
  localparam int unsigned VALUE_WIDTH_DEF = 30;
  localparam int unsigned COUNT_WIDTH_DEF = 16;

  // A clock_op of zero holds the datapath in place.
  localparam int unsigned CLOCK_OP_STALL  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } fib_state_e;

endpackage

// File: rtl/fib_step_divider.sv
// Step divider: counts cycles while enabled and asserts tick once the count
// reaches period-1. A zero period never ticks.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear of the cycle counter
//   en_i          : count enable
//   period_i      : step period in cycles
//   tick_o        : step candidate for the current cycle
module fib_step_divider
  import fib_sequencer_pkg::*;
#(
  parameter int unsigned CLOCK_WIDTH = CLOCK_WIDTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic [CLOCK_WIDTH-1:0] period_i,
  output logic                   tick_o
);

  logic [CLOCK_WIDTH-1:0] div_q, div_d;
  logic                   stall;

  assign stall = (period_i == CLOCK_WIDTH'(CLOCK_OP_STALL));

  // '>=' rather than '==' so a shortened period takes effect on the next
  // cycle instead of waiting for the counter to wrap.
  always_comb begin
    tick_o = en_i && !stall && (div_q >= (period_i - CLOCK_WIDTH'(1)));
  end

  always_comb begin
    div_d = div_q;
    if (clr_i) begin
      div_d = '0;
    end else if (en_i) begin
      div_d = tick_o ? '0 : div_q + CLOCK_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/fib_sequencer.sv
// Run controller for the Fibonacci datapath. Turns the programmed divider and
// enable switch into single-cycle step strobes, runs a bounded step count or
// free-runs, detects wrap of the datapath value and raises a done interrupt.
// Ports:
//   wb_clk_i, wb_rst_ni : clock, asynchronous active-low reset
//   enable_i            : run enable, low aborts a run
//   clock_op_i          : step period in cycles (0 stalls)
//   step_count_i        : steps per run (0 = free-run)
//   start_i, ack_i      : single-cycle start request / done acknowledge
//   value_i             : datapath output
//   fib_clear_o         : reseed strobe to the datapath
//   fib_step_o          : advance strobe to the datapath
//   busy_o, done_o      : run in progress / run finished
//   overflow_o          : sticky wrap flag
//   irq_o               : pulse on entry to DONE
//   steps_done_o        : steps issued in the current/last run
module fib_sequencer
  import fib_sequencer_pkg::*;
#(
  parameter int unsigned CLOCK_WIDTH = CLOCK_WIDTH_DEF,
  parameter int unsigned VALUE_WIDTH = VALUE_WIDTH_DEF,
  parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEF
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic                   enable_i,
  input  logic [CLOCK_WIDTH-1:0] clock_op_i,
  input  logic [COUNT_WIDTH-1:0] step_count_i,
  input  logic                   start_i,
  input  logic                   ack_i,
  input  logic [VALUE_WIDTH-1:0] value_i,
  output logic                   fib_clear_o,
  output logic                   fib_step_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overflow_o,
  output logic                   irq_o,
  output logic [COUNT_WIDTH-1:0] steps_done_o
);

  fib_state_e             state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] steps_done_q, steps_done_d;
  logic [VALUE_WIDTH-1:0] last_value_q, last_value_d;
  logic                   overflow_q, overflow_d;
  logic                   irq_q, irq_d;
  logic                   check_q, check_d;

  logic run_active;
  logic tick;
  logic check_now;
  logic wrap_hit;
  logic count_hit;
  logic step;

  assign run_active = (state_q == ST_RUN) && enable_i;

  fib_step_divider #(
    .CLOCK_WIDTH (CLOCK_WIDTH)
  ) u_div (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rst_ni),
    .clr_i    (state_q == ST_CLEAR),
    .en_i     (run_active),
    .period_i (clock_op_i),
    .tick_o   (tick)
  );

  // The cycle after every step inspects the freshly updated datapath value.
  assign check_now = check_q && (state_q == ST_RUN);
  assign wrap_hit  = check_now && (value_i < last_value_q);
  assign count_hit = check_now && (count_q != '0) && (steps_done_q == count_q);
  assign step      = run_active && tick && !wrap_hit && !count_hit;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i && enable_i) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = enable_i ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (!enable_i)                 state_d = ST_IDLE;
        else if (wrap_hit || count_hit) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start_i && enable_i) state_d = ST_CLEAR;
        else if (ack_i)          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count_d      = count_q;
    steps_done_d = steps_done_q;
    last_value_d = last_value_q;
    overflow_d   = overflow_q;
    check_d      = step;
    irq_d        = (state_d == ST_DONE) && (state_q != ST_DONE);

    if (state_q == ST_CLEAR) begin
      count_d      = step_count_i;
      steps_done_d = '0;
      last_value_d = '0;
    end else begin
      if (step) steps_done_d = steps_done_q + COUNT_WIDTH'(1);
      if (check_now) last_value_d = value_i;
    end

    // Overflow is dropped on the way into CLEAR so a restart from DONE shows
    // a clean flag during the reseed cycle itself.
    if (state_d == ST_CLEAR || state_q == ST_CLEAR) begin
      overflow_d = 1'b0;
    end else if (state_q == ST_DONE && state_d == ST_IDLE) begin
      overflow_d = 1'b0;
    end else if (state_q == ST_RUN && state_d == ST_DONE && wrap_hit) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      steps_done_q <= '0;
      last_value_q <= '0;
      overflow_q   <= 1'b0;
      irq_q        <= 1'b0;
      check_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      steps_done_q <= steps_done_d;
      last_value_q <= last_value_d;
      overflow_q   <= overflow_d;
      irq_q        <= irq_d;
      check_q      <= check_d;
    end
  end

  assign fib_clear_o  = (state_q == ST_CLEAR);
  assign fib_step_o   = step;
  assign busy_o       = (state_q == ST_CLEAR) || (state_q == ST_RUN);
  assign done_o       = (state_q == ST_DONE);
  assign overflow_o   = overflow_q;
  assign irq_o        = irq_q;
  assign steps_done_o = steps_done_q;

endmodule
